// File: rtl/display_timing_pkg.sv
// Shared raster timing constants and helpers for the display timing generator
// and the pixel generator blocks that need the same window bounds.
package display_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    localparam axis_timing_t VGA480_H = '{active: 640,  fp: 16,  sync: 96, bp: 48};
    localparam axis_timing_t VGA480_V = '{active: 480,  fp: 10,  sync: 2,  bp: 33};
    localparam axis_timing_t HD720_H  = '{active: 1280, fp: 110, sync: 40, bp: 220};
    localparam axis_timing_t HD720_V  = '{active: 720,  fp: 5,   sync: 5,  bp: 20};

    localparam int VGA480_CW = 10;
    localparam int HD720_CW  = 11;

    function automatic int axis_total(input int active, input int fp, input int sync,
                                      input int bp);
        return active + fp + sync + bp;
    endfunction

    // Sync window is half-open: [sync_start, sync_end)
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    function automatic bit fits_width(input int value, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return (value >= 0) && (value < (1 << width));
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis counter: counts 0..TOTAL-1 on step and flags the last position.
module timing_axis
    import display_timing_pkg::*;
#(
    parameter int ACTIVE = VGA480_H.active,
    parameter int FP     = VGA480_H.fp,
    parameter int SYNC   = VGA480_H.sync,
    parameter int BP     = VGA480_H.bp,
    parameter int CW     = VGA480_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(axis_total(ACTIVE, FP, SYNC, BP) - 1);

    assign tc = (cnt == LAST);

    // Wrap on terminal count takes priority, so the count never leaves 0..LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/display_timing_param.sv
// Parametrised raster timing generator: H/V counters (stage 0) feeding one
// output register (stage 1) so position, syncs, de and strobes stay aligned.
module display_timing_param
    import display_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA480_H.active,
    parameter int   H_FP     = VGA480_H.fp,
    parameter int   H_SYNC   = VGA480_H.sync,
    parameter int   H_BP     = VGA480_H.bp,
    parameter int   V_ACTIVE = VGA480_V.active,
    parameter int   V_FP     = VGA480_V.fp,
    parameter int   V_SYNC   = VGA480_V.sync,
    parameter int   V_BP     = VGA480_V.bp,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = VGA480_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 || CW <= 0 ||
        !fits_width(H_TOTAL - 1, CW) || !fits_width(V_TOTAL - 1, CW)) begin : g_bad_params
        $error("display_timing_param: zero timing value or totals do not fit in CW bits");
    end

    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CW-1:0] H_SYNC_END = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CW-1:0] V_SYNC_END = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_tc;
    logic          v_tc_unused;
    logic          v_step;

    assign v_step = pix_ce && h_tc;

    timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk  (clk),
        .rst  (rst),
        .step (pix_ce),
        .cnt  (h_cnt),
        .tc   (h_tc)
    );

    timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk  (clk),
        .rst  (rst),
        .step (v_step),
        .cnt  (v_cnt),
        .tc   (v_tc_unused)
    );

    logic h_in_sync;
    logic v_in_sync;
    logic in_active;
    logic at_line_origin;
    logic at_frame_origin;

    assign h_in_sync       = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign v_in_sync       = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign in_active       = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign at_line_origin  = (h_cnt == '0);
    assign at_frame_origin = at_line_origin && (v_cnt == '0);

    // Strobes clear every clk so they stay one clk wide even with pix_ce held high
    always_ff @(posedge clk) begin
        if (rst) begin
            sx          <= '0;
            sy          <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                sx          <= h_cnt;
                sy          <= v_cnt;
                hsync       <= h_in_sync ? H_POL : ~H_POL;
                vsync       <= v_in_sync ? V_POL : ~V_POL;
                de          <= in_active;
                line_start  <= at_line_origin;
                frame_start <= at_frame_origin;
            end
        end
    end

endmodule

// File: doc/display_timing_param.md
# display_timing_param

Parametrised raster timing generator for the VGA output path. It counts horizontal and vertical pixel positions and produces position, sync, data-enable and line/frame start strobes. All timing values and sync polarities are parameters, so the block covers 480p, 720p or any custom mode. There is no PLL inside: it runs on one system clock and advances only on a pixel clock-enable, which lets the same block serve pixel clocks derived from a faster fabric clock.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync active level
- CW, 10, counter/position width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock-enable; timing advances only on cycles where it is high
- sx  out  CW  horizontal position of the current output pixel
- sy  out  CW  vertical position of the current output pixel
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- de  out  1  data enable, high only in the active area
- line_start  out  1  one-clk pulse when pixel (0, y) is presented
- frame_start  out  1  one-clk pulse when pixel (0, 0) is presented

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is defined the same way.
  - The H sync window is [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); the V sync window is defined the same way.
- Elaboration check: fail if H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits, or if any parameter is 0.
- Stage 0 holds the internal counters h_cnt and v_cnt.
  - On pix_ce, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt advances; v_cnt wraps to 0 after V_TOTAL-1.
  - Terminal-count wrap has priority over increment. There is never an out-of-range value.
- Stage 1 is the output register, loaded from the stage-0 state only on pix_ce:
  - sx = h_cnt, sy = v_cnt
  - hsync = H_POL if h_cnt is in the H sync window, else ~H_POL; vsync likewise against v_cnt
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
- All stage-1 outputs describe the same pixel, so no output is skewed against another.
- Strobes:
  - line_start is set on the pix_ce that loads h_cnt == 0, and cleared on the next clk regardless of pix_ce.
  - frame_start works the same way for h_cnt == 0 && v_cnt == 0.
  - The strobes therefore last exactly one clk, even when pix_ce is held high.
- With pix_ce low, all outputs except the strobes hold their values.

## Timing
- Reset (rst high at a clk edge) wins over pix_ce. Afterwards:
  - h_cnt = v_cnt = 0, sx = sy = 0
  - hsync = ~H_POL, vsync = ~V_POL
  - de = 0, line_start = frame_start = 0
- First pix_ce after reset: outputs show pixel (0,0) with de = 1, line_start = 1, frame_start = 1; stage 0 moves to (1,0).
- Latency is 1 pix_ce from the counter state to the outputs. With pix_ce held high, the output pixel rate equals the clk rate.
- Reset asserted mid-frame: the next clk forces the reset values. The frame restarts cleanly, with no partial sync pulse carried over.
- Simultaneous h and v wrap (last pixel of the frame): both counters return to 0 on the same edge.
- Line period is H_TOTAL pix_ce pulses. Frame period is H_TOTAL*V_TOTAL pix_ce pulses.

## Structure
- Shared package display_timing_pkg:
  - default 480p constants
  - a 720p constant set
  - functions for total and sync-window bounds, shared with the pixel generator blocks
- Sub-module timing_axis (instantiated twice, H and V):
  - parameters ACTIVE/FP/SYNC/BP/CW
  - inputs clk, rst, step
  - outputs cnt and tc (terminal count)
  - the V instance's step = pix_ce && H tc

## Test plan
- Defaults, pix_ce = 1:
  - hsync is low for exactly sx 656..751 (96 clks).
  - sx wraps 799 -> 0.
  - vsync is low for sy 490..491.
  - frame_start recurs every 420000 clks.
  - de is high for exactly 307200 clks per frame.
- pix_ce high 1 clk in 4:
  - outputs change only after ce edges, and each held value lasts 4 clks.
  - line_start and frame_start are 1 clk wide.
  - the line takes 3200 clks.
- Tiny mode exhaustive (H 4/1/2/1, V 3/1/1/1, H_POL = V_POL = 1, CW = 4):
  - the full 8x6 sequence is checked against a reference model, including the (7,5) -> (0,0) wrap.
  - sync pulses are active-high.
- Reset mid-frame at (300,200), with pix_ce also high that cycle:
  - next clk gives all reset values.
  - the first following ce presents (0,0) with frame_start = 1.
- 720p parameters (1280/110/40/220, 720/5/5/20, positive polarity, CW = 11):
  - H_TOTAL = 1650, V_TOTAL = 750.
  - hsync is high for sx 1390..1429.
  - vsync is high for sy 725..729.
